// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default timing constants for the reset sequencer.
// The optional watchdog is enabled with the RESET_SEQ_WDT_EN macro.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } seq_state_t;

    localparam int DEFAULT_NUM_STAGES  = 3;
    localparam int DEFAULT_HOLD_CYCLES = 24'hFFFFF0;
    localparam int DEFAULT_STAGE_GAP   = 1024;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_WDT_TIMEOUT = 2 ** 20;

    // Width that holds 0..n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// N-flop synchroniser with asynchronous active-low clear; output is 0 while
// clear_n is low and follows d after STAGES clock edges otherwise.
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic clear_n,
    input  logic d,
    output logic q
);

    logic [STAGES:0] chain;

    assign chain[0] = d;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic ff_reg;

        always_ff @(posedge clock or negedge clear_n) begin
            if (!clear_n) begin
                ff_reg <= 1'b0;
            end else begin
                ff_reg <= chain[gi];
            end
        end

        assign chain[gi+1] = ff_reg;
    end

    assign q = chain[STAGES];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / restart reset sequencer: holds all stages in reset, then releases
// them one by one. Optional run-time watchdog is enabled with RESET_SEQ_WDT_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEFAULT_NUM_STAGES,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int STAGE_GAP   = DEFAULT_STAGE_GAP,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
`ifdef RESET_SEQ_WDT_EN
    ,
    parameter int WDT_TIMEOUT = DEFAULT_WDT_TIMEOUT
`endif
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  sw_reset_req,
`ifdef RESET_SEQ_WDT_EN
    input  logic                  wdt_kick,
`endif
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  all_ready
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int GAP_W  = cnt_width(STAGE_GAP);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

    logic reset_sync_n;
    logic pll_sync;

    reset_sync #(.STAGES(SYNC_STAGES)) u_reset_sync (
        .clock   (clock),
        .clear_n (reset_n),
        .d       (1'b1),
        .q       (reset_sync_n)
    );

    reset_sync #(.STAGES(SYNC_STAGES)) u_pll_sync (
        .clock   (clock),
        .clear_n (reset_n),
        .d       (pll_locked),
        .q       (pll_sync)
    );

    seq_state_t            state_reg, state_next;
    logic [HOLD_W-1:0]     hold_cnt_reg, hold_cnt_next;
    logic [GAP_W-1:0]      gap_cnt_reg, gap_cnt_next;
    logic [NUM_STAGES-1:0] stage_reset_reg, stage_reset_next;
    logic [NUM_STAGES-1:0] stage_shift;
    logic                  all_ready_reg, all_ready_next;
    logic                  restart;

`ifdef RESET_SEQ_WDT_EN
    localparam int WDT_W = cnt_width(WDT_TIMEOUT);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_TIMEOUT - 1);

    logic [WDT_W-1:0] wdt_cnt_reg, wdt_cnt_next;
    logic             wdt_expire;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= WAIT;
            hold_cnt_reg    <= '0;
            gap_cnt_reg     <= '0;
            stage_reset_reg <= '1;
            all_ready_reg   <= 1'b0;
`ifdef RESET_SEQ_WDT_EN
            wdt_cnt_reg     <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            hold_cnt_reg    <= hold_cnt_next;
            gap_cnt_reg     <= gap_cnt_next;
            stage_reset_reg <= stage_reset_next;
            all_ready_reg   <= all_ready_next;
`ifdef RESET_SEQ_WDT_EN
            wdt_cnt_reg     <= wdt_cnt_next;
`endif
        end
    end

`ifdef RESET_SEQ_WDT_EN
    // A kick always wins, even in the cycle the count reaches its limit.
    always_comb begin
        wdt_cnt_next = '0;
        wdt_expire   = 1'b0;
        if (state_reg == RUN && !wdt_kick) begin
            if (wdt_cnt_reg == WDT_LAST) begin
                wdt_expire = 1'b1;
            end else begin
                wdt_cnt_next = wdt_cnt_reg + 1'b1;
            end
        end
    end

    assign restart = (state_reg != WAIT) && (!pll_sync || sw_reset_req || wdt_expire);
`else
    assign restart = (state_reg != WAIT) && (!pll_sync || sw_reset_req);
`endif

    always_comb begin
        state_next       = state_reg;
        hold_cnt_next    = hold_cnt_reg;
        gap_cnt_next     = gap_cnt_reg;
        stage_reset_next = stage_reset_reg;
        all_ready_next   = all_ready_reg;
        // Releasing the next stage is a left shift, so a stage can never clear
        // ahead of the one below it.
        stage_shift      = stage_reset_reg << 1;

        case (state_reg)
            WAIT: begin
                if (reset_sync_n && pll_sync) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    stage_reset_next = stage_shift;
                    hold_cnt_next    = '0;
                    gap_cnt_next     = '0;
                    if (stage_shift == '0) begin
                        state_next     = RUN;
                        all_ready_next = 1'b1;
                    end else begin
                        state_next = RELEASE;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            RELEASE: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    stage_reset_next = stage_shift;
                    gap_cnt_next     = '0;
                    if (stage_shift == '0) begin
                        state_next     = RUN;
                        all_ready_next = 1'b1;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                all_ready_next = 1'b1;
            end
            default: begin
                state_next = WAIT;
            end
        endcase

        // Lock loss, software request and watchdog collapse into one restart.
        if (restart) begin
            state_next       = WAIT;
            hold_cnt_next    = '0;
            gap_cnt_next     = '0;
            stage_reset_next = '1;
            all_ready_next   = 1'b0;
        end
    end

    assign stage_reset = stage_reset_reg;
    assign all_ready   = all_ready_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output transitions are queued
// with their cycle numbers and compared as the outputs change.
module tb_reset_sequencer;

    localparam int NS   = 3;
    localparam int H    = 16;
    localparam int G    = 4;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1;
`ifdef RESET_SEQ_WDT_EN
    localparam int WDT  = 8;
`endif

    typedef struct {
        int            cyc;
        logic [NS-1:0] sr;
        logic          rdy;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          pll_locked;
    logic          sw_reset_req;
`ifdef RESET_SEQ_WDT_EN
    logic          wdt_kick;
`endif
    logic [NS-1:0] stage_reset;
    logic          all_ready;

    int            cyc = 0;
    int            pass_cnt = 0;
    int            total_cnt = 0;
    logic [NS:0]   prev_obs;
    exp_t          exp_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    reset_sequencer #(
        .NUM_STAGES  (NS),
        .HOLD_CYCLES (H),
        .STAGE_GAP   (G),
        .SYNC_STAGES (SYNC)
`ifdef RESET_SEQ_WDT_EN
        ,
        .WDT_TIMEOUT (WDT)
`endif
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
`ifdef RESET_SEQ_WDT_EN
        .wdt_kick     (wdt_kick),
`endif
        .stage_reset  (stage_reset),
        .all_ready    (all_ready)
    );

    // Expected release pattern 111 -> 110 -> 100 -> 000 counted from HOLD entry h.
    task automatic push_seq(input int h);
        for (int i = 0; i < NS; i++) begin
            exp_t e;
            logic [NS-1:0] sr;
            sr = '1;
            sr = sr << (i + 1);
            e.cyc = h + H + i * G;
            e.sr  = sr;
            e.rdy = (i == NS - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_restart(input int at);
        exp_t e;
        e.cyc = at;
        e.sr  = '1;
        e.rdy = 1'b0;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for the next change of {stage_reset, all_ready}.
    task automatic wait_change(input int budget, output logic [NS-1:0] sr,
                               output logic rdy, output int at, output bit to);
        to  = 1'b1;
        sr  = 'x;
        rdy = 1'bx;
        at  = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if ({stage_reset, all_ready} !== prev_obs) begin
                prev_obs = {stage_reset, all_ready};
                sr  = stage_reset;
                rdy = all_ready;
                at  = cyc;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic pll_high_after(input int n);
        repeat (n) @(negedge clock);
        pll_locked = 1'b1;
    endtask

    task automatic sw_pulse_after(input int n);
        repeat (n) @(negedge clock);
        sw_reset_req = 1'b1;
        @(negedge clock);
        sw_reset_req = 1'b0;
    endtask

`ifdef RESET_SEQ_WDT_EN
    task automatic drive_kicks(input int r);
        int ka[5];
        ka = '{7, 14, 21, 28, 36};
        for (int k = 0; k < 5; k++) begin
            while (cyc < r + ka[k] - 1) @(negedge clock);
            wdt_kick = 1'b1;
            @(negedge clock);
            wdt_kick = 1'b0;
        end
    endtask
`endif

    task automatic restart_by_reset(output int base);
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        prev_obs = {{NS{1'b1}}, 1'b0};
        reset_n = 1'b1;
        base = cyc;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;
`ifdef RESET_SEQ_WDT_EN
        wdt_kick     = 1'b1;
`endif
        repeat (3) @(negedge clock);
        total_cnt++;
        if (stage_reset !== 3'b111) $display("FAIL reset_stage: got %b, expected 111", stage_reset);
        else begin pass_cnt++; $display("reset: stage_reset=%b", stage_reset); end
        total_cnt++;
        if (all_ready !== 1'b0) $display("FAIL reset_ready: got %b, expected 0", all_ready);
        else begin pass_cnt++; $display("reset: all_ready=%b", all_ready); end
        prev_obs = {{NS{1'b1}}, 1'b0};
    endtask

    task automatic test_no_lock();
        logic [NS-1:0] sr; logic rdy; int at; bit to; int base;
        @(negedge clock);
        reset_n = 1'b1;
        wait_change(40, sr, rdy, at, to);
        total_cnt++;
        if (!to) $display("FAIL no_lock_idle: got sr=%b rdy=%b at cycle %0d, expected no change", sr, rdy, at);
        else begin pass_cnt++; $display("no_lock: outputs held without lock"); end
        pll_locked = 1'b1;
        base = cyc;
        push_seq(base + SYNC + 1);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            wait_change(300, sr, rdy, at, to);
            total_cnt++;
            if (to || sr !== e.sr || rdy !== e.rdy || at != e.cyc)
                $display("FAIL no_lock_seq: got sr=%b rdy=%b cyc=%0d timeout=%0b, expected sr=%b rdy=%b cyc=%0d", sr, rdy, at, to, e.sr, e.rdy, e.cyc);
            else begin pass_cnt++; $display("no_lock_seq: sr=%b rdy=%b cycle %0d", sr, rdy, at); end
        end
    endtask

    task automatic test_pll_loss(input int len);
        logic [NS-1:0] sr; logic rdy; int at; bit to; int base;
        pll_locked = 1'b0;
        base = cyc;
        fork
            pll_high_after(len);
        join_none
        push_restart(base + SYNC + 1);
        push_seq(base + SYNC + len + 1);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            wait_change(300, sr, rdy, at, to);
            total_cnt++;
            if (to || sr !== e.sr || rdy !== e.rdy || at != e.cyc)
                $display("FAIL pll_loss_%0d: got sr=%b rdy=%b cyc=%0d timeout=%0b, expected sr=%b rdy=%b cyc=%0d", len, sr, rdy, at, to, e.sr, e.rdy, e.cyc);
            else begin pass_cnt++; $display("pll_loss_%0d: sr=%b rdy=%b cycle %0d", len, sr, rdy, at); end
        end
    endtask

    task automatic test_sw_reset();
        logic [NS-1:0] sr; logic rdy; int at; bit to; int base;
        base = cyc;
        fork
            sw_pulse_after(0);
        join_none
        push_restart(base + 1);
        push_seq(base + 2);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            wait_change(300, sr, rdy, at, to);
            total_cnt++;
            if (to || sr !== e.sr || rdy !== e.rdy || at != e.cyc)
                $display("FAIL sw_reset: got sr=%b rdy=%b cyc=%0d timeout=%0b, expected sr=%b rdy=%b cyc=%0d", sr, rdy, at, to, e.sr, e.rdy, e.cyc);
            else begin pass_cnt++; $display("sw_reset: sr=%b rdy=%b cycle %0d", sr, rdy, at); end
        end
    endtask

    task automatic test_sw_coincident();
        logic [NS-1:0] sr; logic rdy; int at; bit to; int base;
        pll_locked = 1'b0;
        base = cyc;
        fork
            pll_high_after(1);
            sw_pulse_after(SYNC);
        join_none
        push_restart(base + SYNC + 1);
        push_seq(base + SYNC + 2);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            wait_change(300, sr, rdy, at, to);
            total_cnt++;
            if (to || sr !== e.sr || rdy !== e.rdy || at != e.cyc)
                $display("FAIL sw_coincident: got sr=%b rdy=%b cyc=%0d timeout=%0b, expected sr=%b rdy=%b cyc=%0d", sr, rdy, at, to, e.sr, e.rdy, e.cyc);
            else begin pass_cnt++; $display("sw_coincident: sr=%b rdy=%b cycle %0d", sr, rdy, at); end
        end
    endtask

    task automatic test_sw_in_hold();
        logic [NS-1:0] sr; logic rdy; int at; bit to; int base;
        restart_by_reset(base);
        repeat (LAT + 5) @(negedge clock);
        fork
            sw_pulse_after(0);
        join_none
        push_seq(base + LAT + 7);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            wait_change(300, sr, rdy, at, to);
            total_cnt++;
            if (to || sr !== e.sr || rdy !== e.rdy || at != e.cyc)
                $display("FAIL sw_in_hold: got sr=%b rdy=%b cyc=%0d timeout=%0b, expected sr=%b rdy=%b cyc=%0d", sr, rdy, at, to, e.sr, e.rdy, e.cyc);
            else begin pass_cnt++; $display("sw_in_hold: sr=%b rdy=%b cycle %0d", sr, rdy, at); end
        end
    endtask

    task automatic test_async_mid_release();
        logic [NS-1:0] sr; logic rdy; int at; bit to; int base;
        exp_t first;
        restart_by_reset(base);
        first.cyc = base + LAT + H;
        first.sr  = 3'b110;
        first.rdy = 1'b0;
        wait_change(300, sr, rdy, at, to);
        total_cnt++;
        if (to || sr !== first.sr || rdy !== first.rdy || at != first.cyc)
            $display("FAIL async_first: got sr=%b rdy=%b cyc=%0d timeout=%0b, expected sr=%b rdy=%b cyc=%0d", sr, rdy, at, to, first.sr, first.rdy, first.cyc);
        else begin pass_cnt++; $display("async_first: sr=%b cycle %0d", sr, at); end
        repeat (2) @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (stage_reset !== 3'b111) $display("FAIL async_stage: got %b, expected 111", stage_reset);
        else begin pass_cnt++; $display("async: stage_reset=%b before next edge", stage_reset); end
        total_cnt++;
        if (all_ready !== 1'b0) $display("FAIL async_ready: got %b, expected 0", all_ready);
        else begin pass_cnt++; $display("async: all_ready=%b before next edge", all_ready); end
        prev_obs = {{NS{1'b1}}, 1'b0};
        @(negedge clock);
        reset_n = 1'b1;
        base = cyc;
        push_seq(base + LAT);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            wait_change(300, sr, rdy, at, to);
            total_cnt++;
            if (to || sr !== e.sr || rdy !== e.rdy || at != e.cyc)
                $display("FAIL async_reseq: got sr=%b rdy=%b cyc=%0d timeout=%0b, expected sr=%b rdy=%b cyc=%0d", sr, rdy, at, to, e.sr, e.rdy, e.cyc);
            else begin pass_cnt++; $display("async_reseq: sr=%b rdy=%b cycle %0d", sr, rdy, at); end
        end
    endtask

    task automatic test_sequence();
        logic [NS-1:0] sr; logic rdy; int at; bit to; int base;
        restart_by_reset(base);
        push_seq(base + LAT);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            wait_change(300, sr, rdy, at, to);
            total_cnt++;
            if (to || sr !== e.sr || rdy !== e.rdy || at != e.cyc)
                $display("FAIL sequence: got sr=%b rdy=%b cyc=%0d timeout=%0b, expected sr=%b rdy=%b cyc=%0d", sr, rdy, at, to, e.sr, e.rdy, e.cyc);
            else begin pass_cnt++; $display("sequence: sr=%b rdy=%b cycle %0d", sr, rdy, at); end
        end
        wait_change(30, sr, rdy, at, to);
        total_cnt++;
        if (!to) $display("FAIL run_stable: got sr=%b rdy=%b at cycle %0d, expected no change", sr, rdy, at);
        else begin pass_cnt++; $display("run_stable: RUN held"); end
    endtask

`ifdef RESET_SEQ_WDT_EN
    task automatic test_wdt();
        logic [NS-1:0] sr; logic rdy; int at; bit to; int base; int r;
        wdt_kick = 1'b0;
        base = cyc;
        push_restart(base + WDT);
        push_seq(base + WDT + 1);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            wait_change(300, sr, rdy, at, to);
            total_cnt++;
            if (to || sr !== e.sr || rdy !== e.rdy || at != e.cyc)
                $display("FAIL wdt_nokick: got sr=%b rdy=%b cyc=%0d timeout=%0b, expected sr=%b rdy=%b cyc=%0d", sr, rdy, at, to, e.sr, e.rdy, e.cyc);
            else begin pass_cnt++; $display("wdt_nokick: sr=%b rdy=%b cycle %0d", sr, rdy, at); end
        end
        r = cyc;
        fork
            drive_kicks(r);
        join_none
        push_restart(r + 36 + WDT);
        push_seq(r + 36 + WDT + 1);
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            wait_change(300, sr, rdy, at, to);
            total_cnt++;
            if (to || sr !== e.sr || rdy !== e.rdy || at != e.cyc)
                $display("FAIL wdt_kicked: got sr=%b rdy=%b cyc=%0d timeout=%0b, expected sr=%b rdy=%b cyc=%0d", sr, rdy, at, to, e.sr, e.rdy, e.cyc);
            else begin pass_cnt++; $display("wdt_kicked: sr=%b rdy=%b cycle %0d", sr, rdy, at); end
        end
        wdt_kick = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_no_lock();
        test_pll_loss(1);
        test_pll_loss(12);
        test_sw_reset();
        test_sw_coincident();
        test_sw_in_hold();
        test_async_mid_release();
        test_sequence();
`ifdef RESET_SEQ_WDT_EN
        test_wdt();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "global timeout");
    end

endmodule
